// File: rtl/game_judge.sv
// Round referee: FSM, per-second countdown, catch debounce and cheese count -> 2-bit gameover code.
// Result registers one cycle after the deciding input; no backpressure, every input is acted on when sampled.
module game_judge #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECONDS  = 60,
  parameter int CHEESE_TARGET  = 5,
  parameter int CATCH_FRAMES   = 3,
  parameter int SPRITE_W       = 48,
  parameter int SPRITE_H       = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [11:0] tom_xpos,
  input  logic [11:0] tom_ypos,
  input  logic [11:0] jerry_xpos,
  input  logic [11:0] jerry_ypos,
  input  logic        cheese_got,
  output logic [1:0]  gameover,
  output logic [6:0]  time_left,
  output logic [3:0]  cheese_cnt,
  output logic        playing
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]    TIME_INIT   = 7'(ROUND_SECONDS);
  localparam logic [3:0]    CHEESE_GOAL = 4'(CHEESE_TARGET);
  localparam logic [3:0]    CATCH_GOAL  = 4'(CATCH_FRAMES);
  localparam logic [11:0]   OVL_W       = 12'(SPRITE_W);
  localparam logic [11:0]   OVL_H       = 12'(SPRITE_H);

  localparam logic [1:0] GO_NONE  = 2'b00;
  localparam logic [1:0] GO_TOM   = 2'b10;
  localparam logic [1:0] GO_JERRY = 2'b01;

  logic [1:0]    state;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    catch_cnt;

  logic [11:0]   dx, dy;
  logic          overlap, frame_wrap, tom_win, jerry_win;
  logic [FW-1:0] frame_nxt;
  logic [6:0]    time_nxt;
  logic [3:0]    catch_nxt, cheese_nxt;

  always_comb begin
    dx         = (tom_xpos >= jerry_xpos) ? (tom_xpos - jerry_xpos) : (jerry_xpos - tom_xpos);
    dy         = (tom_ypos >= jerry_ypos) ? (tom_ypos - jerry_ypos) : (jerry_ypos - tom_ypos);
    overlap    = (dx < OVL_W) && (dy < OVL_H);
    frame_wrap = frame_tick && (frame_cnt == FRAME_LAST);

    frame_nxt = frame_cnt;
    if (frame_tick)
      frame_nxt = frame_wrap ? '0 : frame_cnt + 1'b1;

    time_nxt = time_left;
    if (frame_wrap && (time_left != 7'd0))
      time_nxt = time_left - 7'd1;

    catch_nxt = catch_cnt;
    if (frame_tick)
      catch_nxt = overlap ? catch_cnt + 4'd1 : 4'd0;

    cheese_nxt = cheese_cnt;
    if (cheese_got && (cheese_cnt != 4'hF))
      cheese_nxt = cheese_cnt + 4'd1;

    // Counters sit below their goals while in PLAY, so equality marks the deciding cycle.
    tom_win   = frame_tick && overlap && (catch_nxt == CATCH_GOAL);
    jerry_win = (time_nxt == 7'd0) || (cheese_nxt == CHEESE_GOAL);
  end

  always_ff @(posedge clk) begin
    if (rst || reset) begin
      state      <= IDLE;
      gameover   <= GO_NONE;
      time_left  <= TIME_INIT;
      cheese_cnt <= 4'd0;
      playing    <= 1'b0;
      frame_cnt  <= '0;
      catch_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= PLAY;
            playing    <= 1'b1;
            time_left  <= TIME_INIT;
            cheese_cnt <= 4'd0;
            frame_cnt  <= '0;
            catch_cnt  <= 4'd0;
          end
        end
        PLAY: begin
          frame_cnt  <= frame_nxt;
          time_left  <= time_nxt;
          catch_cnt  <= catch_nxt;
          cheese_cnt <= cheese_nxt;
          if (tom_win) begin
            state    <= DONE;
            playing  <= 1'b0;
            gameover <= GO_TOM;
          end else if (jerry_win) begin
            state    <= DONE;
            playing  <= 1'b0;
            gameover <= GO_JERRY;
          end
        end
        DONE: ;
        default: begin
          state    <= IDLE;
          playing  <= 1'b0;
          gameover <= GO_NONE;
        end
      endcase
    end
  end

endmodule
